serdes_tx: RTL and testbench

Framed parallel-to-serial transmitter for the SERDES link. It loads an 8-bit parallel word and shifts it onto a single serial line inside a start/parity/stop frame. While `send` stays high it sends frames back to back. It flags an aborted frame on `err`. Its serial output feeds the peer receiver block (`serdes_rx`), which is specified separately.

---
 rtl/serdes_pkg.sv | 32 +++
 rtl/serdes_bit_tick.sv | 31 +++
 rtl/serdes_tx.sv | 132 +++++++++++++
 tb/tb_serdes_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: definitions shared by the SERDES transmitter and receiver.
//   serdes_state_e : frame FSM states
//   START_BIT/STOP_BIT : fixed framing bit values
//   frame_bits()   : number of serial bits in one frame for a given word width
//   calc_parity()  : parity bit of a word (even, or odd when requested)
package serdes_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } serdes_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 32;

  function automatic int frame_bits(input int data_w);
    return data_w + 3;
  endfunction

  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                       input logic                    odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/serdes_bit_tick.sv
// serdes_bit_tick: bit-period counter for the serial frame.
//   i_clk     : clock
//   i_rst_n   : synchronous active-low reset
//   i_restart : restart the period (FSM is changing state this cycle)
//   o_tick    : high in the last cycle of each bit period
module serdes_bit_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // With CLKS_PER_BIT=1 LAST is 0, so the counter stays at 0 and ticks every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/serdes_tx.sv
// serdes_tx: framed parallel-to-serial transmitter.
//   CLOCK_50 : clock (rising edge)
//   resetN   : synchronous active-low reset
//   Pin      : parallel word, captured when a frame starts
//   send     : level transmit enable; frames repeat back to back while high
//   Sout     : registered serial line, idles high
//   err      : registered one-cycle pulse when a frame is aborted
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, waiting for send
// S_START  | driving the start bit
// S_DATA   | driving data bits, LSB first
// S_PARITY | driving the parity bit
// S_STOP   | driving the stop bit; reload here if send held
module serdes_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int ODD_PARITY   = 0
) (
  input  logic              CLOCK_50,
  input  logic              resetN,
  input  logic [DATA_W-1:0] Pin,
  input  logic              send,
  output logic              Sout,
  output logic              err
);
  import serdes_pkg::*;

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic ODD = (ODD_PARITY != 0);

  serdes_state_e     r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_parity, w_parity_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic              r_sout, w_sout_nxt;
  logic              r_err, w_err_nxt;
  logic              w_tick;
  logic              w_in_frame;
  logic              w_load;

  serdes_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_tick (
    .i_clk    (CLOCK_50),
    .i_rst_n  (resetN),
    .i_restart(w_state_nxt != r_state),
    .o_tick   (w_tick)
  );

  // Abortable part of the frame: dropping send here discards the frame.
  assign w_in_frame = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_PARITY);
  assign w_load     = send && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

  always_ff @(posedge CLOCK_50) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_idx    <= '0;
      r_sout   <= STOP_BIT;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_idx    <= w_idx_nxt;
      r_sout   <= w_sout_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (send) w_state_nxt = S_START;
      end
      S_START: begin
        if (!send)       w_state_nxt = S_IDLE;
        else if (w_tick) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (!send)                             w_state_nxt = S_IDLE;
        else if (w_tick && (r_idx == IDX_LAST)) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (!send)       w_state_nxt = S_IDLE;
        else if (w_tick) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick) w_state_nxt = send ? S_START : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so Sout is computed for the state being entered
  // from the shift register value it will hold in that state.
  always_comb begin
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_idx_nxt    = r_idx;
    w_err_nxt    = w_in_frame && !send;

    if (w_load) begin
      w_shift_nxt  = Pin;
      w_parity_nxt = calc_parity(PARITY_MAX_W'(Pin), ODD);
    end else if ((r_state == S_DATA) && w_tick) begin
      w_shift_nxt = r_shift >> 1;
    end

    if (r_state != S_DATA) begin
      w_idx_nxt = '0;
    end else if (w_tick) begin
      w_idx_nxt = r_idx + IDX_W'(1);
    end

    case (w_state_nxt)
      S_START:  w_sout_nxt = START_BIT;
      S_DATA:   w_sout_nxt = w_shift_nxt[0];
      S_PARITY: w_sout_nxt = w_parity_nxt;
      default:  w_sout_nxt = STOP_BIT;
    endcase
  end

  assign Sout = r_sout;
  assign err  = r_err;

endmodule

// File: tb/tb_serdes_tx.sv
// tb_serdes_tx: drives two transmitters (1 clk/bit even parity, 3 clk/bit odd
// parity) from the same stimulus and compares every cycle against a frame-list
// reference model.
module tb_serdes_tx;
  import serdes_pkg::*;

  localparam int DW  = 8;
  localparam int NFB = frame_bits(DW);

  logic          clk = 1'b0;
  logic          resetN;
  logic          send;
  logic [DW-1:0] Pin;
  logic          sout0, err0, sout1, err1;

  always #5 clk = ~clk;

  serdes_tx #(.DATA_W(DW), .CLKS_PER_BIT(1), .ODD_PARITY(0)) u_dut0 (
    .CLOCK_50(clk), .resetN(resetN), .Pin(Pin), .send(send), .Sout(sout0), .err(err0)
  );

  serdes_tx #(.DATA_W(DW), .CLKS_PER_BIT(3), .ODD_PARITY(1)) u_dut1 (
    .CLOCK_50(clk), .resetN(resetN), .Pin(Pin), .send(send), .Sout(sout1), .err(err1)
  );

  // Reference model: a frame is a list of NFB bits; position counts cycles
  // since the frame began, bit = position / clocks-per-bit.
  int   m_cpb [2] = '{1, 3};
  bit   m_odd [2] = '{1'b0, 1'b1};
  bit   m_act [2] = '{1'b0, 1'b0};
  int   m_pos [2] = '{0, 0};
  bit   m_frm [2][NFB];
  logic m_sout[2] = '{1'b1, 1'b1};
  logic m_err [2] = '{1'b0, 1'b0};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic load_frame(input int d, input logic [DW-1:0] w);
    m_frm[d][0] = START_BIT;
    for (int i = 0; i < DW; i++) m_frm[d][1+i] = w[i];
    m_frm[d][DW+1] = (^w) ^ m_odd[d];
    m_frm[d][DW+2] = STOP_BIT;
    m_pos[d] = 0;
    m_act[d] = 1'b1;
  endtask

  task automatic model_edge(input int d);
    m_err[d] = 1'b0;
    if (!resetN) begin
      m_act[d]  = 1'b0;
      m_sout[d] = 1'b1;
    end else if (!m_act[d]) begin
      if (send) begin
        load_frame(d, Pin);
        m_sout[d] = m_frm[d][0];
      end else begin
        m_sout[d] = 1'b1;
      end
    end else if (!send && (m_pos[d] / m_cpb[d]) < NFB - 1) begin
      m_act[d]  = 1'b0;
      m_sout[d] = 1'b1;
      m_err[d]  = 1'b1;
    end else begin
      m_pos[d]++;
      if (m_pos[d] == NFB * m_cpb[d]) begin
        if (send) load_frame(d, Pin);
        else      m_act[d] = 1'b0;
      end
      m_sout[d] = m_act[d] ? m_frm[d][m_pos[d] / m_cpb[d]] : 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b at time %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic [DW-1:0] p);
    resetN = r;
    send   = s;
    Pin    = p;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check("sout_cpb1_even", sout0, m_sout[0]);
    check("err_cpb1_even",  err0,  m_err[0]);
    check("sout_cpb3_odd",  sout1, m_sout[1]);
    check("err_cpb3_odd",   err1,  m_err[1]);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 8'($urandom));
  endtask

  initial begin
    int len;
    bit s;

    // Reset, then a long idle stretch.
    cyc(1'b0, 1'b0, 8'h00);
    idle(20);

    // Single 0x00 frame; send drops during STOP of the fast instance.
    repeat (11) cyc(1'b1, 1'b1, 8'h00);
    idle(40);

    // 0xA5, with Pin scrambled after the load edge.
    cyc(1'b1, 1'b1, 8'hA5);
    repeat (10) cyc(1'b1, 1'b1, 8'($urandom));
    idle(40);

    // Back-to-back frames after reset; fifth frame aborts in its data bits.
    cyc(1'b0, 1'b0, 8'h00);
    repeat (50) cyc(1'b1, 1'b1, 8'h00);
    idle(40);

    // Abort during DATA bit 3.
    repeat (5) cyc(1'b1, 1'b1, 8'h3C);
    idle(40);

    // Reset in the middle of DATA, then a clean restart.
    repeat (5) cyc(1'b1, 1'b1, 8'h5A);
    cyc(1'b0, 1'b1, 8'h5A);
    repeat (12) cyc(1'b1, 1'b1, 8'h96);
    idle(40);

    // Long send so the slow instance also runs frames back to back.
    repeat (80) cyc(1'b1, 1'b1, 8'($urandom));
    idle(40);

    // Randomized runs of send with occasional resets.
    repeat (60) begin
      len = int'($urandom_range(1, 40));
      s   = ($urandom_range(0, 3) != 0);
      repeat (len) cyc(($urandom_range(0, 199) != 0), s, 8'($urandom));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
